// File: rtl/fp_mac_pkg.sv
// Shared types and sizing helpers for the floating-point MAC accumulator.
package fp_mac_pkg;

   localparam int DEF_EXP_WIDTH  = 8;
   localparam int DEF_MANT_WIDTH = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bits needed to hold a beat count in the range 0..max_len.
   function automatic int count_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational fused multiply-add (a*b + c) on a sign/exponent/mantissa
// format. Denormal inputs are flushed to zero, any Inf/NaN input yields a
// canonical quiet NaN, overflow saturates to the largest finite value and
// underflow flushes to a signed zero. Rounding is round-to-nearest-even on
// the retained alignment window; bits shifted past that window are dropped.
module mac_unit #(
   parameter int BIT_WIDTH  = 16,
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 7
) (
   input  logic [BIT_WIDTH-1:0] a_i,
   input  logic [BIT_WIDTH-1:0] b_i,
   input  logic [BIT_WIDTH-1:0] c_i,
   output logic [BIT_WIDTH-1:0] result_o,
   output logic                 exception_o,
   output logic                 overflow_o,
   output logic                 underflow_o
);

   localparam int E       = EXP_WIDTH;
   localparam int M       = MANT_WIDTH;
   localparam int PW      = 2 * M + 2;        // exact product width, point below bit 2M
   localparam int GW      = M + 3;            // extra fraction bits kept during alignment
   localparam int AW      = PW + GW;          // aligned operand width
   localparam int SW      = AW + 1;           // sum width including carry
   localparam int FP      = 2 * M + GW;       // position of the unit bit in the sum
   localparam int BIAS    = (1 << (E - 1)) - 1;
   localparam int EXP_ALL = (1 << E) - 1;

   logic          sa, sb, sc, sx, rs;
   logic [E-1:0]  ea, eb, ec;
   logic [M-1:0]  ma, mb, mc;
   logic [PW-1:0] siga, sigb, prod;
   logic [AW-1:0] xm, ym, xa, ya;
   logic [SW-1:0] sum, norm;
   logic [M:0]    mant_r;
   logic          x_zero, y_zero, special, guard, sticky, rnd;
   int            ex_raw, ey_raw, ex, ey, emax, k, er;

   assign sa = a_i[BIT_WIDTH-1];
   assign sb = b_i[BIT_WIDTH-1];
   assign sc = c_i[BIT_WIDTH-1];
   assign ea = a_i[BIT_WIDTH-2 -: E];
   assign eb = b_i[BIT_WIDTH-2 -: E];
   assign ec = c_i[BIT_WIDTH-2 -: E];
   assign ma = a_i[M-1:0];
   assign mb = b_i[M-1:0];
   assign mc = c_i[M-1:0];

   // Align product and addend, add, normalise, round and classify.
   always_comb begin
      special = (ea == '1) || (eb == '1) || (ec == '1);
      x_zero  = (ea == '0) || (eb == '0);
      y_zero  = (ec == '0);
      sx      = sa ^ sb;

      siga = {{(PW-M-1){1'b0}}, 1'b1, ma};
      sigb = {{(PW-M-1){1'b0}}, 1'b1, mb};
      prod = siga * sigb;

      xm = x_zero ? '0 : {prod, {GW{1'b0}}};
      ym = y_zero ? '0 : {1'b0, 1'b1, mc, {M{1'b0}}, {GW{1'b0}}};

      ex_raw = int'(ea) + int'(eb) - BIAS;
      ey_raw = int'(ec);
      // A zero operand borrows the other exponent so it never drives alignment.
      ex = x_zero ? ey_raw : ex_raw;
      ey = y_zero ? ex_raw : ey_raw;

      if (ex >= ey) begin
         emax = ex;
         xa   = xm;
         ya   = ym >> (ex - ey);
      end else begin
         emax = ey;
         xa   = xm >> (ey - ex);
         ya   = ym;
      end

      if (sx == sc) begin
         sum = {1'b0, xa} + {1'b0, ya};
         rs  = sx;
      end else if (xa >= ya) begin
         sum = {1'b0, xa - ya};
         rs  = sx;
      end else begin
         sum = {1'b0, ya - xa};
         rs  = sc;
      end

      k = 0;
      for (int i = 0; i < SW; i++) begin
         if (sum[i]) k = i;
      end
      norm = sum << (SW - 1 - k);
      er   = emax + k - FP;

      guard  = norm[SW-M-2];
      sticky = |norm[SW-M-3:0];
      rnd    = guard & (sticky | norm[SW-M-1]);
      mant_r = {1'b0, norm[SW-2 -: M]} + {{M{1'b0}}, rnd};
      // Mantissa all ones rounded up: the value moves to the next binade.
      if (mant_r[M]) er = er + 1;

      exception_o = 1'b0;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;
      result_o    = {rs, er[E-1:0], mant_r[M-1:0]};

      if (special) begin
         exception_o = 1'b1;
         result_o    = '0;
         result_o[BIT_WIDTH-2 -: E] = '1;
         result_o[M-1] = 1'b1;
      end else if (!norm[SW-1]) begin
         result_o = '0;
      end else if (er >= EXP_ALL) begin
         overflow_o = 1'b1;
         result_o   = {rs, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
      end else if (er <= 0) begin
         underflow_o = 1'b1;
         result_o    = {rs, {(BIT_WIDTH-1){1'b0}}};
      end
   end

endmodule

// File: rtl/fp_mac_accumulator.sv
// Streaming dot-product engine: accumulates a*b per accepted beat on top of a
// per-vector bias, then presents the sum, beat count and sticky flags on a
// registered output handshake.
module fp_mac_accumulator
   import fp_mac_pkg::*;
#(
   parameter  int EXP_WIDTH  = DEF_EXP_WIDTH,
   parameter  int MANT_WIDTH = DEF_MANT_WIDTH,
   localparam int BIT_WIDTH  = 1 + EXP_WIDTH + MANT_WIDTH,
   parameter  int MAX_LEN    = 256,
   localparam int CNT_W      = count_width(MAX_LEN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BIT_WIDTH-1:0] in_a,
   input  logic [BIT_WIDTH-1:0] in_b,
   input  logic [BIT_WIDTH-1:0] in_bias,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   output logic [BIT_WIDTH-1:0] out_result,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_exception,
   output logic                 out_overflow,
   output logic                 out_underflow,
   output logic                 out_len_err,
   output logic                 out_valid,
   input  logic                 out_ready
);

   state_t               state_q;
   logic [BIT_WIDTH-1:0] acc_q, acc_d, mac_c;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 exc_q, ovf_q, unf_q;
   logic                 exc_d, ovf_d, unf_d;
   logic                 mac_exc, mac_ovf, mac_unf;
   logic                 accept, len_err, last_eff;
   logic [BIT_WIDTH-1:0] out_result_q;
   logic [CNT_W-1:0]     out_count_q;
   logic                 out_exc_q, out_ovf_q, out_unf_q, out_len_q, out_valid_q;

   assign in_ready = (state_q != DONE);
   assign accept   = in_valid && in_ready;
   // The first beat of a vector seeds from the bias, later beats from the running sum.
   assign mac_c    = (state_q == IDLE) ? in_bias : acc_q;

   mac_unit #(
      .BIT_WIDTH  (BIT_WIDTH),
      .EXP_WIDTH  (EXP_WIDTH),
      .MANT_WIDTH (MANT_WIDTH)
   ) u_mac (
      .a_i         (in_a),
      .b_i         (in_b),
      .c_i         (mac_c),
      .result_o    (acc_d),
      .exception_o (mac_exc),
      .overflow_o  (mac_ovf),
      .underflow_o (mac_unf)
   );

   // Next beat count, sticky flags and effective end-of-vector for this beat.
   always_comb begin
      if (state_q == IDLE) begin
         cnt_d = CNT_W'(1);
         exc_d = mac_exc;
         ovf_d = mac_ovf;
         unf_d = mac_unf;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         exc_d = exc_q | mac_exc;
         ovf_d = ovf_q | mac_ovf;
         unf_d = unf_q | mac_unf;
      end
      len_err  = !in_last && (cnt_d == CNT_W'(MAX_LEN));
      last_eff = in_last || len_err;
   end

   // Vector FSM with accumulator state and the registered result port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         exc_q        <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         out_result_q <= '0;
         out_count_q  <= '0;
         out_exc_q    <= 1'b0;
         out_ovf_q    <= 1'b0;
         out_unf_q    <= 1'b0;
         out_len_q    <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_d;
                  exc_q <= exc_d;
                  ovf_q <= ovf_d;
                  unf_q <= unf_d;
                  if (last_eff) begin
                     out_result_q <= acc_d;
                     out_count_q  <= cnt_d;
                     out_exc_q    <= exc_d;
                     out_ovf_q    <= ovf_d;
                     out_unf_q    <= unf_d;
                     out_len_q    <= len_err;
                     out_valid_q  <= 1'b1;
                     state_q      <= DONE;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_result    = out_result_q;
   assign out_count     = out_count_q;
   assign out_exception = out_exc_q;
   assign out_overflow  = out_ovf_q;
   assign out_underflow = out_unf_q;
   assign out_len_err   = out_len_q;
   assign out_valid     = out_valid_q;

endmodule

// File: tb/tb_fp_mac_accumulator.sv
// Bench for fp_mac_accumulator with bfloat16 operands and MAX_LEN=4.
`timescale 1ns/1ps
module tb_fp_mac_accumulator;

   localparam int EW = 8;
   localparam int MW = 7;
   localparam int BW = 16;
   localparam int ML = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [BW-1:0] in_a, in_b, in_bias;
   logic          in_valid, in_ready, in_last;
   logic [BW-1:0] out_result;
   logic [CW-1:0] out_count;
   logic          out_exception, out_overflow, out_underflow, out_len_err;
   logic          out_valid, out_ready;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] bias;
      logic [15:0] res;
      logic [3:0]  flags;   // {exception, overflow, underflow, len_err}
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  cnt;
      logic [3:0]  flags;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[11];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fp_mac_accumulator #(
      .EXP_WIDTH  (EW),
      .MANT_WIDTH (MW),
      .MAX_LEN    (ML)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_bias       (in_bias),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_last       (in_last),
      .out_result    (out_result),
      .out_count     (out_count),
      .out_exception (out_exception),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_len_err   (out_len_err),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, want);
      end
   endfunction

   task automatic push_exp(input logic [15:0] res, input logic [2:0] cnt, input logic [3:0] flags);
      exp_t e;
      e.res   = res;
      e.cnt   = cnt;
      e.flags = flags;
      sbq.push_back(e);
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic drive_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] bias, input logic last);
      int waitc;
      waitc    = 0;
      in_a     = a;
      in_b     = b;
      in_bias  = bias;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && waitc < 40) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL beat_accept_timeout in_ready=%b want=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(sbq.size()), 32'd0);
   endtask

   // Result monitor: pops the scoreboard on every output handshake.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output got=%0h want=none", out_result);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("out_result", 32'(out_result), 32'(e.res));
            check("out_count", 32'(out_count), 32'(e.cnt));
            check("out_flags", 32'({out_exception, out_overflow, out_underflow, out_len_err}),
                  32'(e.flags));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 4'b0000}; // 1*1+1 = 2
      tbl[1]  = '{16'h4000, 16'h4040, 16'hBF80, 16'h40A0, 4'b0000}; // 2*3-1 = 5
      tbl[2]  = '{16'hC000, 16'h4040, 16'h0000, 16'hC0C0, 4'b0000}; // -2*3 = -6
      tbl[3]  = '{16'h3FC0, 16'h3FC0, 16'h3F40, 16'h4040, 4'b0000}; // 1.5*1.5+0.75 = 3
      tbl[4]  = '{16'h4000, 16'h4000, 16'hC080, 16'h0000, 4'b0000}; // 2*2-4 = 0
      tbl[5]  = '{16'h0080, 16'h0080, 16'h0000, 16'h0000, 4'b0010}; // underflow
      tbl[6]  = '{16'h7F7F, 16'h7F7F, 16'h0000, 16'h7F7F, 4'b0100}; // overflow saturates
      tbl[7]  = '{16'h7F80, 16'h3F80, 16'h0000, 16'h7FC0, 4'b1000}; // Inf -> NaN
      tbl[8]  = '{16'h0000, 16'h0000, 16'h4110, 16'h4110, 4'b0000}; // 0*0+9 = 9
      tbl[9]  = '{16'h3F00, 16'h3F00, 16'h3E80, 16'h3F00, 4'b0000}; // 0.25+0.25 = 0.5
      tbl[10] = '{16'h4040, 16'hBF80, 16'h4040, 16'h0000, 4'b0000}; // 3*-1+3 = 0

      rst_n     = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_bias   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_flags", 32'({out_exception, out_overflow, out_underflow, out_len_err}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single-beat vectors from the table
      for (int i = 0; i < 11; i++) begin
         push_exp(tbl[i].res, 3'd1, tbl[i].flags);
         drive_beat(tbl[i].a, tbl[i].b, tbl[i].bias, 1'b1);
      end

      // Three-beat dot product: 2 + 6 + 1 = 9
      push_exp(16'h4110, 3'd3, 4'b0000);
      drive_beat(16'h3F80, 16'h4000, 16'h0000, 1'b0);
      drive_beat(16'h4000, 16'h4040, 16'h3F80, 1'b0);
      drive_beat(16'h3F00, 16'h4000, 16'h3F80, 1'b1);

      // Single beat with bias, output one cycle after acceptance
      push_exp(16'h4000, 3'd1, 4'b0000);
      drive_beat(16'h3F80, 16'h3F80, 16'h3F80, 1'b1);
      check("latency_out_valid", 32'(out_valid), 32'd1);

      // Overflow stays sticky after a beat that leaves the sum in range
      push_exp(16'h7F7F, 3'd2, 4'b0100);
      drive_beat(16'h7F7F, 16'h7F7F, 16'h0000, 1'b0);
      drive_beat(16'h0000, 16'h0000, 16'h0000, 1'b1);

      // Length limit: four beats without last close the vector with len_err
      push_exp(16'h4080, 3'd4, 4'b0001);
      for (int i = 0; i < 4; i++) drive_beat(16'h3F80, 16'h3F80, 16'h0000, 1'b0);
      check("len_out_valid", 32'(out_valid), 32'd1);
      check("len_in_ready", 32'(in_ready), 32'd0);
      // The fifth beat waits and opens the next vector (1, then 1*1+1 = 2)
      push_exp(16'h4000, 3'd2, 4'b0000);
      drive_beat(16'h3F80, 16'h3F80, 16'h0000, 1'b0);
      drive_beat(16'h3F80, 16'h3F80, 16'h0000, 1'b1);
      wait_drain();

      // Backpressure: result held for 10 cycles, then released
      out_ready = 1'b0;
      push_exp(16'h4040, 3'd1, 4'b0000);
      drive_beat(16'h4000, 16'h3F80, 16'h3F80, 1'b1);
      for (int i = 0; i < 10; i++) begin
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_result", 32'(out_result), 32'h4040);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_out_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);

      // Reset mid-vector discards the partial sum
      drive_beat(16'h3F80, 16'h3F80, 16'h4000, 1'b0);
      drive_beat(16'h3F80, 16'h3F80, 16'h4000, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid2", 32'(out_valid), 32'd0);
      check("midrst_out_count", 32'(out_count), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      push_exp(16'h4000, 3'd1, 4'b0000);
      drive_beat(16'h3F80, 16'h3F80, 16'h3F80, 1'b1);
      wait_drain();
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
